// File: rtl/armleocpu_decode_pkg.sv
// Shared opclass codes, RV32 opcode constants and the decode pipeline entry type.
package armleocpu_decode_pkg;

  typedef enum logic [3:0] {
    OPCLASS_ALU_REG = 4'd0,
    OPCLASS_ALU_IMM = 4'd1,
    OPCLASS_LOAD    = 4'd2,
    OPCLASS_STORE   = 4'd3,
    OPCLASS_BRANCH  = 4'd4,
    OPCLASS_JAL     = 4'd5,
    OPCLASS_JALR    = 4'd6,
    OPCLASS_LUI     = 4'd7,
    OPCLASS_AUIPC   = 4'd8,
    OPCLASS_SYSTEM  = 4'd9,
    OPCLASS_FENCE   = 4'd10,
    OPCLASS_MULDIV  = 4'd11,
    OPCLASS_ILLEGAL = 4'd15
  } opclass_e;

  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    opclass_e    opclass;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
    logic        exc_start;
    logic [31:0] cause;
  } entry_t;

  // Bubble entry (addi x0,x0,0); the PC is carried so a kill does not move d2e_pc.
  function automatic entry_t nop_entry(input logic [31:0] pc);
    entry_t e;
    e           = '0;
    e.instr     = NOP_INSTR;
    e.pc        = pc;
    e.opclass   = OPCLASS_ALU_IMM;
    return e;
  endfunction

endpackage

// File: rtl/armleocpu_decode_comb.sv
// Pure combinational RV32I decoder: instruction -> opclass, register indices, immediate.
// MULDIV decode is enabled by defining ARMLEOCPU_DECODE_RVM_EN.
module armleocpu_decode_comb
  import armleocpu_decode_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  opclass,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output logic        illegal
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  opclass_e    cls;

  assign opcode = instr[6:0];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    cls = OPCLASS_ILLEGAL;
    imm = '0;
    if (instr[1:0] == 2'b11) begin
      case (opcode)
        OPCODE_OP: begin
          if (funct7 == 7'b0000000 || funct7 == 7'b0100000) cls = OPCLASS_ALU_REG;
`ifdef ARMLEOCPU_DECODE_RVM_EN
          else if (funct7 == 7'b0000001) cls = OPCLASS_MULDIV;
`endif
        end
        OPCODE_OP_IMM:   begin cls = OPCLASS_ALU_IMM; imm = imm_i; end
        OPCODE_LOAD:     begin cls = OPCLASS_LOAD;    imm = imm_i; end
        OPCODE_STORE:    begin cls = OPCLASS_STORE;   imm = imm_s; end
        OPCODE_BRANCH:   begin cls = OPCLASS_BRANCH;  imm = imm_b; end
        OPCODE_JAL:      begin cls = OPCLASS_JAL;     imm = imm_j; end
        OPCODE_JALR:     begin cls = OPCLASS_JALR;    imm = imm_i; end
        OPCODE_LUI:      begin cls = OPCLASS_LUI;     imm = imm_u; end
        OPCODE_AUIPC:    begin cls = OPCLASS_AUIPC;   imm = imm_u; end
        OPCODE_SYSTEM:   begin cls = OPCLASS_SYSTEM;  imm = imm_i; end
        OPCODE_MISC_MEM: begin cls = OPCLASS_FENCE;   imm = imm_i; end
        default:         cls = OPCLASS_ILLEGAL;
      endcase
    end
  end

  assign opclass = cls;
  assign illegal = (cls == OPCLASS_ILLEGAL);

endmodule

// File: rtl/armleocpu_decode.sv
// Decode stage: decodes fetch output into a main register with a one-entry skid buffer.
// Define ARMLEOCPU_DECODE_RVM_EN to decode the M extension as MULDIV.
module armleocpu_decode
  import armleocpu_decode_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] f2e_instr,
  input  logic [31:0] f2e_pc,
  input  logic        f2e_exc_start,
  input  logic [31:0] f2e_cause,
  output logic        e2f_ready,
  input  logic        e_ready,
  input  logic        e_kill,
  output logic [31:0] d2e_instr,
  output logic [31:0] d2e_pc,
  output logic [3:0]  d2e_opclass,
  output logic [4:0]  d2e_rd,
  output logic [4:0]  d2e_rs1,
  output logic [4:0]  d2e_rs2,
  output logic [31:0] d2e_imm,
  output logic        d2e_illegal,
  output logic        d2e_exc_start,
  output logic [31:0] d2e_cause
);

  logic [3:0]  dec_opclass;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [31:0] dec_imm;
  logic        dec_illegal;

  armleocpu_decode_comb u_comb (
    .instr   (f2e_instr),
    .opclass (dec_opclass),
    .rd      (dec_rd),
    .rs1     (dec_rs1),
    .rs2     (dec_rs2),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  entry_t in_entry;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   skid_full_q, skid_full_d;
  logic   e2f_ready_q;

  always_comb begin
    in_entry.instr     = f2e_instr;
    in_entry.pc        = f2e_pc;
    in_entry.opclass   = opclass_e'(dec_opclass);
    in_entry.rd        = dec_rd;
    in_entry.rs1       = dec_rs1;
    in_entry.rs2       = dec_rs2;
    in_entry.imm       = dec_imm;
    // A fetch-side exception outranks a decode fault on the same slot.
    in_entry.illegal   = dec_illegal & ~f2e_exc_start;
    in_entry.exc_start = f2e_exc_start;
    in_entry.cause     = f2e_cause;
  end

  always_comb begin
    main_d      = main_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    if (e_kill) begin
      main_d      = nop_entry(main_q.pc);
      skid_full_d = 1'b0;
    end else if (skid_full_q) begin
      if (e_ready) begin
        main_d      = skid_q;
        skid_full_d = 1'b0;
      end
    end else if (e_ready) begin
      main_d = in_entry;
    end else begin
      skid_d      = in_entry;
      skid_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state uses non-blocking assignments; the skid payload is reset too so no X ever reaches main.
      main_q      <= nop_entry(RESET_PC);
      skid_q      <= nop_entry(RESET_PC);
      skid_full_q <= 1'b0;
      e2f_ready_q <= 1'b1;
    end else begin
      main_q      <= main_d;
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
      e2f_ready_q <= ~skid_full_d;
    end
  end

  assign e2f_ready     = e2f_ready_q;
  assign d2e_instr     = main_q.instr;
  assign d2e_pc        = main_q.pc;
  assign d2e_opclass   = main_q.opclass;
  assign d2e_rd        = main_q.rd;
  assign d2e_rs1       = main_q.rs1;
  assign d2e_rs2       = main_q.rs2;
  assign d2e_imm       = main_q.imm;
  assign d2e_illegal   = main_q.illegal;
  assign d2e_exc_start = main_q.exc_start;
  assign d2e_cause     = main_q.cause;

endmodule

// File: tb/tb_armleocpu_decode.sv
// Self-checking bench for armleocpu_decode: directed scenarios plus a randomized run
// against a queue-based reference model (honours ARMLEOCPU_DECODE_RVM_EN).
module tb_armleocpu_decode;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  opclass;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
    logic        exc_start;
    logic [31:0] cause;
  } exp_t;

  localparam logic [31:0] RST_PC = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] f2e_instr = 32'h13;
  logic [31:0] f2e_pc = 32'h0;
  logic        f2e_exc_start = 1'b0;
  logic [31:0] f2e_cause = 32'h0;
  logic        e2f_ready;
  logic        e_ready = 1'b1;
  logic        e_kill = 1'b0;
  logic [31:0] d2e_instr, d2e_pc, d2e_imm, d2e_cause;
  logic [3:0]  d2e_opclass;
  logic [4:0]  d2e_rd, d2e_rs1, d2e_rs2;
  logic        d2e_illegal, d2e_exc_start;

  int n_checks = 0;
  int n_fail = 0;

  armleocpu_decode #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .f2e_instr(f2e_instr), .f2e_pc(f2e_pc),
    .f2e_exc_start(f2e_exc_start), .f2e_cause(f2e_cause),
    .e2f_ready(e2f_ready), .e_ready(e_ready), .e_kill(e_kill),
    .d2e_instr(d2e_instr), .d2e_pc(d2e_pc), .d2e_opclass(d2e_opclass),
    .d2e_rd(d2e_rd), .d2e_rs1(d2e_rs1), .d2e_rs2(d2e_rs2), .d2e_imm(d2e_imm),
    .d2e_illegal(d2e_illegal), .d2e_exc_start(d2e_exc_start), .d2e_cause(d2e_cause)
  );

  always #5 clk = ~clk;

  function automatic exp_t nop_exp(input logic [31:0] pc);
    exp_t e;
    e = '0;
    e.instr = 32'h13;
    e.pc = pc;
    e.opclass = 4'd1;
    return e;
  endfunction

  // Reference decode written from the RV32I format tables using arithmetic shifts.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic exc, input logic [31:0] cause);
    exp_t e;
    int   s;
    logic [31:0] ii, is, ib, iu, ij;
    s  = ins;
    ii = 32'(s >>> 20);
    is = 32'((s >>> 25) <<< 5) | 32'(ins[11:7]);
    ib = 32'((s >>> 31) <<< 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    iu = ins & 32'hFFFF_F000;
    ij = 32'((s >>> 31) <<< 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    e = '0;
    e.instr = ins; e.pc = pc; e.exc_start = exc; e.cause = cause;
    e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
    e.opclass = 4'd15;
    case (ins[6:0])
      7'h33: begin
        if (ins[31:25] == 7'h00 || ins[31:25] == 7'h20) e.opclass = 4'd0;
`ifdef ARMLEOCPU_DECODE_RVM_EN
        else if (ins[31:25] == 7'h01) e.opclass = 4'd11;
`endif
      end
      7'h13: begin e.opclass = 4'd1;  e.imm = ii; end
      7'h03: begin e.opclass = 4'd2;  e.imm = ii; end
      7'h23: begin e.opclass = 4'd3;  e.imm = is; end
      7'h63: begin e.opclass = 4'd4;  e.imm = ib; end
      7'h6F: begin e.opclass = 4'd5;  e.imm = ij; end
      7'h67: begin e.opclass = 4'd6;  e.imm = ii; end
      7'h37: begin e.opclass = 4'd7;  e.imm = iu; end
      7'h17: begin e.opclass = 4'd8;  e.imm = iu; end
      7'h73: begin e.opclass = 4'd9;  e.imm = ii; end
      7'h0F: begin e.opclass = 4'd10; e.imm = ii; end
      default: e.opclass = 4'd15;
    endcase
    e.illegal = (e.opclass == 4'd15) && !exc;
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.instr = d2e_instr; o.pc = d2e_pc; o.opclass = d2e_opclass;
    o.rd = d2e_rd; o.rs1 = d2e_rs1; o.rs2 = d2e_rs2; o.imm = d2e_imm;
    o.illegal = d2e_illegal; o.exc_start = d2e_exc_start; o.cause = d2e_cause;
    return o;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic er, input logic kill);
    f2e_instr = ins; f2e_pc = pc; e_ready = er; e_kill = kill;
    f2e_exc_start = 1'b0; f2e_cause = 32'h0;
  endtask

  task automatic do_reset();
    drive(32'h13, 32'h0, 1'b1, 1'b0);
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t exp_v, obs;
    drive(32'h13, 32'h0, 1'b1, 1'b0);
    rst_n = 1'b0;
    cycle();
    cycle();
    exp_v = nop_exp(RST_PC);
    obs = observed();
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", obs, exp_v);
    end
    n_checks++;
    if (e2f_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_e2f_ready: got %b expected 1", e2f_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    do_reset();
    drive(32'hFFB1_0093, 32'h0000_3000, 1'b1, 1'b0);
    cycle();
    n_checks++;
    if (d2e_opclass !== 4'd1 || d2e_rd !== 5'd1 || d2e_rs1 !== 5'd2 || d2e_imm !== 32'hFFFF_FFFB
        || d2e_pc !== 32'h3000 || d2e_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL addi_decode: got cls=%0d rd=%0d rs1=%0d imm=%h pc=%h ill=%b expected cls=1 rd=1 rs1=2 imm=fffffffb pc=00003000 ill=0",
               d2e_opclass, d2e_rd, d2e_rs1, d2e_imm, d2e_pc, d2e_illegal);
    end
  endtask

  task automatic test_stall_stream();
    logic [31:0] pcs [3];
    logic        er  [4];
    logic [31:0] exp_pc [4];
    logic        exp_rdy [4];
    int          idx;
    logic        acc;
    pcs = '{32'h2000, 32'h2004, 32'h2008};
    er = '{1'b1, 1'b0, 1'b1, 1'b1};
    exp_pc = '{32'h2000, 32'h2000, 32'h2004, 32'h2008};
    exp_rdy = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      if (idx < 3) drive(32'h0010_0093 + (32'(idx) << 7), pcs[idx], er[c], 1'b0);
      else drive(32'h13, 32'h200C, er[c], 1'b0);
      acc = e2f_ready;
      cycle();
      if (acc) idx++;
      n_checks++;
      if (d2e_pc !== exp_pc[c] || e2f_ready !== exp_rdy[c]) begin
        n_fail++;
        $display("FAIL stall_stream_c%0d: got pc=%h rdy=%b expected pc=%h rdy=%b",
                 c, d2e_pc, e2f_ready, exp_pc[c], exp_rdy[c]);
      end
    end
  endtask

  task automatic test_kill();
    do_reset();
    drive(32'h0050_0093, 32'h4000, 1'b0, 1'b0);
    cycle();
    n_checks++;
    if (e2f_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_skid_fill: got rdy=%b expected 0", e2f_ready);
    end
    drive(32'h0060_0093, 32'h4004, 1'b0, 1'b1);
    cycle();
    n_checks++;
    if (d2e_instr !== 32'h13 || e2f_ready !== 1'b1 || d2e_opclass !== 4'd1 || d2e_pc !== RST_PC) begin
      n_fail++;
      $display("FAIL kill_flush: got instr=%h rdy=%b cls=%0d pc=%h expected instr=00000013 rdy=1 cls=1 pc=%h",
               d2e_instr, e2f_ready, d2e_opclass, d2e_pc, RST_PC);
    end
    drive(32'h0070_0093, 32'h5000, 1'b1, 1'b0);
    cycle();
    n_checks++;
    if (d2e_pc !== 32'h5000 || d2e_instr !== 32'h0070_0093) begin
      n_fail++;
      $display("FAIL kill_after: got pc=%h instr=%h expected pc=00005000 instr=00700093", d2e_pc, d2e_instr);
    end
  endtask

  task automatic test_muldiv();
    logic [3:0] exp_cls;
    logic       exp_ill;
`ifdef ARMLEOCPU_DECODE_RVM_EN
    exp_cls = 4'd11; exp_ill = 1'b0;
`else
    exp_cls = 4'd15; exp_ill = 1'b1;
`endif
    do_reset();
    drive(32'h0220_8033, 32'h7000, 1'b1, 1'b0);
    cycle();
    n_checks++;
    if (d2e_opclass !== exp_cls || d2e_illegal !== exp_ill) begin
      n_fail++;
      $display("FAIL muldiv: got cls=%0d ill=%b expected cls=%0d ill=%b", d2e_opclass, d2e_illegal, exp_cls, exp_ill);
    end
  endtask

  task automatic test_exc();
    do_reset();
    drive(32'h0, 32'h7100, 1'b1, 1'b0);
    f2e_exc_start = 1'b1;
    f2e_cause = 32'h1;
    cycle();
    n_checks++;
    if (d2e_exc_start !== 1'b1 || d2e_cause !== 32'h1 || d2e_illegal !== 1'b0 || d2e_pc !== 32'h7100) begin
      n_fail++;
      $display("FAIL exc_pass: got exc=%b cause=%h ill=%b pc=%h expected exc=1 cause=00000001 ill=0 pc=00007100",
               d2e_exc_start, d2e_cause, d2e_illegal, d2e_pc);
    end
  endtask

  task automatic test_reset_midstall();
    do_reset();
    drive(32'h0010_0093, 32'h6000, 1'b1, 1'b0);
    cycle();
    drive(32'h0020_0093, 32'h6004, 1'b0, 1'b0);
    cycle();
    n_checks++;
    if (e2f_ready !== 1'b0 || d2e_pc !== 32'h6000) begin
      n_fail++;
      $display("FAIL midstall_setup: got rdy=%b pc=%h expected rdy=0 pc=00006000", e2f_ready, d2e_pc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (d2e_pc !== RST_PC || e2f_ready !== 1'b1 || d2e_instr !== 32'h13) begin
      n_fail++;
      $display("FAIL midstall_async_reset: got pc=%h rdy=%b instr=%h expected pc=%h rdy=1 instr=00000013",
               d2e_pc, e2f_ready, d2e_instr, RST_PC);
    end
    cycle();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [11];
    logic [31:0] ins;
    int          r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0F};
    ins = $urandom;
    r = $urandom_range(0, 19);
    if (r < 3) return 32'h13;
    if (r < 5) return ins;
    ins[6:0] = ops[$urandom_range(0, 10)];
    if (ins[6:0] == 7'h33) begin
      case ($urandom_range(0, 3))
        0: ins[31:25] = 7'h00;
        1: ins[31:25] = 7'h20;
        2: ins[31:25] = 7'h01;
        default: ;
      endcase
    end
    return ins;
  endfunction

  task automatic test_random();
    exp_t q[$];
    exp_t in_e, obs;
    logic acc;
    int   fails_here;
    do_reset();
    q.delete();
    q.push_back(nop_exp(RST_PC));
    fails_here = 0;
    for (int c = 0; c < 600; c++) begin
      f2e_instr = rand_instr();
      f2e_pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      f2e_exc_start = ($urandom_range(0, 9) == 0);
      f2e_cause = f2e_exc_start ? $urandom : 32'h0;
      e_ready = ($urandom_range(0, 2) != 0);
      e_kill = ($urandom_range(0, 24) == 0);
      in_e = ref_decode(f2e_instr, f2e_pc, f2e_exc_start, f2e_cause);
      acc = (q.size() < 2);
      cycle();
      if (e_kill) begin
        in_e = nop_exp(q[0].pc);
        q.delete();
        q.push_back(in_e);
      end else begin
        if (e_ready) void'(q.pop_front());
        if (acc) q.push_back(in_e);
      end
      obs = observed();
      n_checks++;
      if (obs !== q[0] || e2f_ready !== (q.size() < 2)) begin
        n_fail++;
        fails_here++;
        if (fails_here <= 10)
          $display("FAIL random_c%0d: got %h rdy=%b expected %h rdy=%b", c, obs, e2f_ready, q[0], q.size() < 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_stall_stream();
    test_kill();
    test_muldiv();
    test_exc();
    test_reset_midstall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
